heap_shift_sequencer: RTL and testbench



---
 rtl/heap_shift_sequencer.sv | 147 ++++++++++++++
 tb/tb_heap_shift_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/heap_shift_sequencer.sv
// heap_shift_sequencer: inserts (shiftUp) or removes (shiftDown) one element of a
// heap array by moving neighbours one at a time through a single-port,
// synchronous-read heap RAM.
//   clock, reset         : rising-edge clock, synchronous active-high reset
//   req_*                : request handshake and operands, latched when valid && ready
//   done, error          : one-cycle completion pulse, error flags a rejected request
//   done_size/done_value : resulting array size and removed element, held until next done
//   mem_*                : heap RAM port; read data returns the cycle after the address
module heap_shift_sequencer #(
   parameter int MemoryElementWidth = 12,
   parameter int NArea              = 4,
   parameter int NArrays            = 2,
   parameter int AddrW              = 3,
   parameter int ArrW               = 1,
   parameter int PosW               = 3
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic                          req_op,
   input  logic [ArrW-1:0]               req_array,
   input  logic [PosW-1:0]               req_pos,
   input  logic [MemoryElementWidth-1:0] req_value,
   input  logic [PosW-1:0]               req_size,
   output logic                          done,
   output logic                          error,
   output logic [PosW-1:0]               done_size,
   output logic [MemoryElementWidth-1:0] done_value,
   output logic [AddrW-1:0]              mem_addr,
   output logic                          mem_we,
   output logic [MemoryElementWidth-1:0] mem_wdata,
   input  logic [MemoryElementWidth-1:0] mem_rdata
);
   if (NArea * NArrays > (1 << AddrW)) begin : g_addr_check
      $error("AddrW too small for NArea*NArrays");
   end

   typedef enum logic [2:0] {IDLE, RD, WR, INS, RDX, CAP, DONE} state_t;

   localparam logic [PosW-1:0]  P1 = PosW'(1);
   localparam logic [AddrW-1:0] A1 = AddrW'(1);

   state_t                          state, state_n;
   logic                            op, err, accept, bad, we_n;
   logic [AddrW-1:0]                base, req_base, addr_n;
   logic [PosW-1:0]                 pos, size, idx, idx_n;
   logic [MemoryElementWidth-1:0]   value;

   assign accept    = req_valid && req_ready;
   assign req_base  = AddrW'(req_array) * AddrW'(NArea);
   assign bad       = req_op ? (req_size == '0 || req_pos >= req_size)
                             : (req_size == PosW'(NArea) || req_pos > req_size);
   assign done      = state == DONE;
   assign error     = done && err;
   // A moved element goes straight from the RAM output register to the write port.
   assign mem_wdata = state == WR ? mem_rdata : value;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      addr_n  = mem_addr;
      we_n    = 1'b0;
      case (state)
         IDLE: if (accept) begin
            if (bad) begin
               state_n = DONE;
            end else if (req_op) begin
               state_n = RDX;
               addr_n  = req_base + AddrW'(req_pos);
               idx_n   = req_pos + P1;
            end else if (req_pos == req_size) begin
               state_n = INS;
               addr_n  = req_base + AddrW'(req_pos);
               we_n    = 1'b1;
            end else begin
               state_n = RD;
               idx_n   = req_size - P1;
               addr_n  = req_base + AddrW'(req_size - P1);
            end
         end
         RDX: state_n = CAP;
         CAP: begin
            state_n = idx < size ? RD : DONE;
            addr_n  = base + AddrW'(idx);
         end
         RD: begin
            state_n = WR;
            we_n    = 1'b1;
            addr_n  = op ? base + AddrW'(idx) - A1 : base + AddrW'(idx) + A1;
         end
         WR: if (op) begin
            state_n = idx + P1 < size ? RD : DONE;
            idx_n   = idx + P1;
            addr_n  = base + AddrW'(idx + P1);
         end else if (idx > pos) begin
            state_n = RD;
            idx_n   = idx - P1;
            addr_n  = base + AddrW'(idx - P1);
         end else begin
            state_n = INS;
            addr_n  = base + AddrW'(pos);
            we_n    = 1'b1;
         end
         INS:     state_n = DONE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         mem_addr   <= '0;
         mem_we     <= 1'b0;
         idx        <= '0;
         op         <= 1'b0;
         err        <= 1'b0;
         base       <= '0;
         pos        <= '0;
         size       <= '0;
         value      <= '0;
         done_size  <= '0;
         done_value <= '0;
      end else begin
         state     <= state_n;
         req_ready <= state_n == IDLE;
         mem_addr  <= addr_n;
         mem_we    <= we_n;
         idx       <= idx_n;
         if (accept) begin
            op    <= req_op;
            err   <= bad;
            base  <= req_base;
            pos   <= req_pos;
            size  <= req_size;
            value <= req_value;
         end
         if (state == CAP)
            done_value <= mem_rdata;
         if (accept && bad)
            done_size <= req_size;
         else if (state_n == DONE && state != IDLE && state != DONE)
            done_size <= op ? size - P1 : size + P1;
      end
   end
endmodule

// File: tb/tb_heap_shift_sequencer.sv
// tb_heap_shift_sequencer: directed and random shiftUp/shiftDown requests checked
// against a queue-based model of the heap arrays.
module tb_heap_shift_sequencer;
   logic        clock = 0, reset = 1;
   logic        req_valid = 0, req_ready, req_op = 0;
   logic [0:0]  req_array = 0;
   logic [2:0]  req_pos = 0, req_size = 0, done_size;
   logic [11:0] req_value = 0, done_value, mem_wdata, rdata;
   logic        done, error, mem_we;
   logic [2:0]  mem_addr;

   logic [11:0] ram [8];
   logic [11:0] model [8];
   logic        bd_we = 0;
   logic [2:0]  bd_addr = 0;
   logic [11:0] bd_data = 0;

   int checks = 0, errors = 0;
   int cyc, writes, last_done, last_wr, e_lat, e_wr, e_size, sz [2];
   bit active = 0, e_err;
   logic [11:0] dval_m = 0;

   heap_shift_sequencer dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_array(req_array), .req_pos(req_pos), .req_value(req_value),
      .req_size(req_size), .done(done), .error(error), .done_size(done_size),
      .done_value(done_value), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (bd_we) ram[bd_addr] <= bd_data;
      else if (mem_we) ram[mem_addr] <= mem_wdata;
      rdata <= ram[mem_addr];
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clock) if (active) begin
      int bad = 0;
      cyc++;
      if (mem_we) writes++;
      chk("ready_busy", req_ready, 0);
      chk("done", done, cyc == e_lat);
      chk("error", error, (cyc == e_lat) && e_err);
      if (done && last_done < 0) last_done = cyc;
      if (cyc == e_lat) begin
         chk("done_size", done_size, e_size);
         chk("done_value", done_value, dval_m);
         chk("writes", writes, e_wr);
         for (int k = 0; k < 8; k++) if (ram[k] !== model[k]) bad++;
         chk("heap", bad, 0);
         last_wr = writes;
         active = 0;
      end
   end

   task automatic set_ram(input int a, input int d);
      bd_we = 1; bd_addr = 3'(a); bd_data = 12'(d);
      @(negedge clock);
      bd_we = 0;
      model[a] = 12'(d);
   endtask

   task automatic run_req(input bit op, input int arr, input int pos, input int val,
                          input int size, input bit keep);
      int n = 0;
      int base = arr * 4;
      logic [11:0] q [$];
      while (!req_ready && n < 20) begin @(negedge clock); n++; end
      chk("ready_idle", req_ready, 1);
      req_valid = 1; req_op = op; req_array = 1'(arr); req_pos = 3'(pos);
      req_value = 12'(val); req_size = 3'(size);
      for (int k = 0; k < size && k < 4; k++) q.push_back(model[base + k]);
      e_err = op ? (size == 0 || pos >= size) : (size == 4 || pos > size);
      if (e_err) begin
         e_lat = 1; e_wr = 0; e_size = size;
      end else if (!op) begin
         q.insert(pos, 12'(val));
         for (int k = 0; k <= size; k++) model[base + k] = q[k];
         e_lat = 2 * (size - pos) + 2; e_wr = size - pos + 1; e_size = size + 1;
      end else begin
         dval_m = q[pos];
         q.delete(pos);
         for (int k = 0; k < size - 1; k++) model[base + k] = q[k];
         e_lat = 2 * (size - 1 - pos) + 3; e_wr = size - 1 - pos; e_size = size - 1;
      end
      @(posedge clock);
      #1;
      cyc = 0; writes = 0; last_done = -1; active = 1;
      if (!keep) begin
         req_valid = 0; req_op = 1'($urandom); req_array = 1'($urandom);
         req_pos = 3'($urandom); req_value = 12'($urandom); req_size = 3'($urandom);
      end
      n = 0;
      while (active && n < 40) begin @(negedge clock); n++; end
   endtask

   initial begin
      #300000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      @(negedge clock);
      for (int a = 0; a < 8; a++) set_ram(a, a < 4 ? int'($urandom % 4096) : a - 4);
      chk("rst_ready", req_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      chk("rst_we", mem_we, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_dsize", done_size, 0);
      chk("rst_dvalue", done_value, 0);
      reset = 0;
      @(negedge clock);
      chk("ready_after_rst", req_ready, 1);
      repeat (3) begin @(negedge clock); chk("idle_we", mem_we, 0); end
      sz[0] = 4; sz[1] = 3;

      run_req(0, 1, 0, 99, 3, 0);
      chk("up_done_cyc", last_done, 8);
      chk("up_writes", last_wr, 4);
      chk("up_size", done_size, 4);
      chk("up_h4", ram[4], 99); chk("up_h5", ram[5], 0);
      chk("up_h6", ram[6], 1);  chk("up_h7", ram[7], 2);

      run_req(0, 1, 0, 5, 4, 0);
      chk("full_done_cyc", last_done, 1);
      chk("full_size", done_size, 4);
      chk("full_h4", ram[4], 99);

      run_req(1, 1, 1, 0, 4, 0);
      chk("down_done_cyc", last_done, 7);
      chk("down_value", done_value, 0);
      chk("down_size", done_size, 3);
      chk("down_h5", ram[5], 1); chk("down_h6", ram[6], 2); chk("down_h7", ram[7], 2);

      run_req(1, 0, 0, 0, 0, 0);
      chk("empty_done_cyc", last_done, 1);

      run_req(0, 1, 3, 7, 3, 0);
      chk("tail_done_cyc", last_done, 2);
      chk("tail_writes", last_wr, 1);
      chk("tail_h7", ram[7], 7);
      chk("tail_size", done_size, 4);

      run_req(1, 1, 0, 0, 4, 1);
      run_req(0, 1, 0, 11, 3, 0);
      sz[1] = 4;

      @(negedge clock);
      req_valid = 1; req_op = 0; req_array = 0; req_pos = 0; req_size = 3; req_value = 5;
      @(posedge clock);
      #1 req_valid = 0;
      repeat (3) begin @(negedge clock); chk("mid_busy", req_ready, 0); end
      reset = 1;
      repeat (2) begin
         @(negedge clock);
         chk("mid_rst_done", done, 0);
         chk("mid_rst_ready", req_ready, 0);
      end
      reset = 0;
      @(negedge clock);
      chk("mid_ready", req_ready, 1);
      chk("mid_no_done", done, 0);
      for (int k = 0; k < 4; k++) model[k] = ram[k];
      dval_m = 0; sz[0] = 3;

      for (int t = 0; t < 60; t++) begin
         int arr = int'($urandom % 2);
         int size = ($urandom % 8 == 0) ? int'($urandom % 5) : sz[arr];
         int pos = int'($urandom_range(0, size + 1));
         run_req(1'($urandom), arr, pos, int'($urandom % 4096), size, 0);
         if (!e_err) sz[arr] = e_size;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
